// File: rtl/prog_lut_pkg.sv
// Shared types and sizing helpers for the programmable LUT evaluator.
package prog_lut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    READ
  } state_t;

  function automatic int lut_depth(input int n);
    return 1 << n;
  endfunction

  // A single channel still needs a one-bit selector.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/prog_lut_eval_if.sv
// Evaluation and serial-config bus of prog_lut_eval.
// PROG_LUT_READBACK_EN adds the table readback signals.
interface prog_lut_eval_if import prog_lut_pkg::*; #(
  parameter int N_IN = 3,
  parameter int N_CH = 2
);
  localparam int CH_W = ch_width(N_CH);

  logic                 in_valid;
  logic [N_CH*N_IN-1:0] in_data;
  logic                 out_valid;
  logic [N_CH-1:0]      out_y;

  logic                 cfg_start;
  logic [CH_W-1:0]      cfg_ch;
  logic                 cfg_valid;
  logic                 cfg_bit;
  logic                 cfg_busy;
  logic                 cfg_done;

`ifdef PROG_LUT_READBACK_EN
  logic                 rd_start;
  logic [CH_W-1:0]      rd_ch;
  logic                 rd_valid;
  logic                 rd_bit;

  modport master (
    output in_valid, in_data, cfg_start, cfg_ch, cfg_valid, cfg_bit, rd_start, rd_ch,
    input  out_valid, out_y, cfg_busy, cfg_done, rd_valid, rd_bit
  );

  modport slave (
    input  in_valid, in_data, cfg_start, cfg_ch, cfg_valid, cfg_bit, rd_start, rd_ch,
    output out_valid, out_y, cfg_busy, cfg_done, rd_valid, rd_bit
  );
`else
  modport master (
    output in_valid, in_data, cfg_start, cfg_ch, cfg_valid, cfg_bit,
    input  out_valid, out_y, cfg_busy, cfg_done
  );

  modport slave (
    input  in_valid, in_data, cfg_start, cfg_ch, cfg_valid, cfg_bit,
    output out_valid, out_y, cfg_busy, cfg_done
  );
`endif

endinterface

// File: rtl/prog_lut_eval_lut_channel.sv
// One channel: committed truth table plus registered lookup.
// PROG_LUT_READBACK_EN exposes the committed table for readback.
module lut_channel import prog_lut_pkg::*; #(
  parameter int                         N_IN = 3,
  parameter logic [lut_depth(N_IN)-1:0] INIT = 8'hF4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [lut_depth(N_IN)-1:0] wdata,
  input  logic                       en,
  input  logic [N_IN-1:0]            idx,
  output logic                       y
`ifdef PROG_LUT_READBACK_EN
  ,
  output logic [lut_depth(N_IN)-1:0] contents
`endif
);

  logic [lut_depth(N_IN)-1:0] tbl;

  // NOTE: the table is a small flop bank, not RAM, so it resets to INIT and a
  // reset in the middle of a load restores INIT rather than the previous table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= INIT;
    end else if (we) begin
      tbl <= wdata;
    end
  end

  // NOTE: non-blocking assignments make this lookup read the pre-commit table
  // on the commit edge; the new table is first visible one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= 1'b0;
    end else if (en) begin
      y <= tbl[idx];
    end
  end

`ifdef PROG_LUT_READBACK_EN
  assign contents = tbl;
`endif

endmodule

// File: rtl/prog_lut_eval.sv
// N_CH-channel run-time-programmable LUT evaluator with serial atomic config.
// PROG_LUT_READBACK_EN adds a READ state that shifts a committed table out.
module prog_lut_eval import prog_lut_pkg::*; #(
  parameter int                         N_IN = 3,
  parameter int                         N_CH = 2,
  parameter logic [lut_depth(N_IN)-1:0] INIT = 8'hF4
) (
  input logic             clk,
  input logic             rst_n,
  prog_lut_eval_if.slave  bus
);

  localparam int DEPTH = lut_depth(N_IN);
  localparam int CH_W  = ch_width(N_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] shadow_q, shadow_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic             commit;
  logic [N_CH-1:0]  we;
  logic [N_CH-1:0]  y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
    end
  end

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          state_d  = LOAD;
          sel_d    = bus.cfg_ch;
          cnt_d    = '0;
          shadow_d = '0;
        end
`ifdef PROG_LUT_READBACK_EN
        else if (bus.rd_start) begin
          state_d = READ;
          sel_d   = bus.rd_ch;
          cnt_d   = '0;
        end
`endif
      end
      LOAD: begin
        if (bus.cfg_start) begin
          sel_d    = bus.cfg_ch;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (bus.cfg_valid) begin
          shadow_d = {shadow_q[DEPTH-2:0], bus.cfg_bit};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: state_d = IDLE;
`ifdef PROG_LUT_READBACK_EN
      READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign commit       = (state_q == COMMIT);
  assign bus.cfg_busy = (state_q == LOAD);
  assign bus.cfg_done = commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
    end
  end

`ifdef PROG_LUT_READBACK_EN
  logic [DEPTH-1:0] contents [N_CH];
  logic [DEPTH-1:0] rd_word;
  logic [N_IN-1:0]  rd_idx;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_q == CH_W'(k)) begin
        rd_word = contents[k];
      end
    end
  end

  // DEPTH-1-cnt is the bitwise complement of cnt while cnt < DEPTH.
  assign rd_idx       = ~cnt_q[N_IN-1:0];
  assign bus.rd_valid = (state_q == READ);
  assign bus.rd_bit   = bus.rd_valid & rd_word[rd_idx];
`endif

  // An out-of-range selector matches no channel, so the commit is dropped.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign we[k] = commit && (sel_q == CH_W'(k));

    lut_channel #(
      .N_IN (N_IN),
      .INIT (INIT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we[k]),
      .wdata    (shadow_q),
      .en       (bus.in_valid),
      .idx      (bus.in_data[k*N_IN +: N_IN]),
      .y        (y[k])
`ifdef PROG_LUT_READBACK_EN
      ,
      .contents (contents[k])
`endif
    );
  end

  assign bus.out_y = y;

endmodule

// File: tb/tb_prog_lut_eval.sv
// Scoreboard bench for prog_lut_eval against a transaction-level table model.
// With PROG_LUT_READBACK_EN defined it also drives and checks readback.
module tb_prog_lut_eval;
  import prog_lut_pkg::*;

  localparam int N_IN  = 3;
  localparam int N_CH  = 2;
  localparam int DEPTH = lut_depth(N_IN);
  localparam int CH_W  = ch_width(N_CH);
  localparam logic [DEPTH-1:0] INIT = 8'hF4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  prog_lut_eval_if #(.N_IN(N_IN), .N_CH(N_CH)) bus ();

  prog_lut_eval #(.N_IN(N_IN), .N_CH(N_CH), .INIT(INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DEPTH-1:0] m_tab [N_CH];
  bit               m_loading;
  bit               m_commit;
  bit               m_out_valid;
  logic [N_CH-1:0]  m_hold;
  int               m_ch;
  bit               m_bits [$];
  logic [N_CH-1:0]  exp_q [$];
`ifdef PROG_LUT_READBACK_EN
  int               m_reading;
  int               m_rd_ch;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] model_eval(input logic [N_CH*N_IN-1:0] d);
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) begin
      r[k] = m_tab[k][d[k*N_IN +: N_IN]];
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) m_tab[k] = INIT;
    m_loading   = 0;
    m_commit    = 0;
    m_out_valid = 0;
    m_hold      = '0;
    m_ch        = 0;
    m_bits.delete();
    exp_q.delete();
`ifdef PROG_LUT_READBACK_EN
    m_reading = 0;
    m_rd_ch   = 0;
`endif
  endfunction

  // Model: at each edge, evaluate with the tables as they stand, then apply
  // the config rules (first received bit lands at index DEPTH-1).
  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (bus.in_valid) begin
          m_hold = model_eval(bus.in_data);
          exp_q.push_back(m_hold);
        end
        m_out_valid = bus.in_valid;
        if (m_commit) begin
          if (m_ch < N_CH) begin
            for (int i = 0; i < DEPTH; i++) m_tab[m_ch][DEPTH-1-i] = m_bits[i];
          end
          m_commit = 0;
        end
`ifdef PROG_LUT_READBACK_EN
        else if (m_reading > 0) begin
          m_reading--;
        end
`endif
        else if (bus.cfg_start) begin
          m_loading = 1;
          m_ch      = int'(bus.cfg_ch);
          m_bits.delete();
        end else if (m_loading && bus.cfg_valid) begin
          m_bits.push_back(bus.cfg_bit);
          if (m_bits.size() == DEPTH) begin
            m_loading = 0;
            m_commit  = 1;
          end
        end
`ifdef PROG_LUT_READBACK_EN
        else if (!m_loading && bus.rd_start) begin
          m_reading = DEPTH;
          m_rd_ch   = int'(bus.rd_ch);
        end
`endif
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle, popping the scoreboard on out_valid.
  initial begin : monitor
    logic [N_CH-1:0] e;
    forever begin
      @(negedge clk);
      check("out_valid", bus.out_valid, m_out_valid);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_y: got 0x%0h with no expected entry at %0t", bus.out_y, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_y", bus.out_y, e);
        end
      end else begin
        check("out_y_hold", bus.out_y, m_hold);
      end
      check("cfg_busy", bus.cfg_busy, m_loading);
      check("cfg_done", bus.cfg_done, m_commit);
`ifdef PROG_LUT_READBACK_EN
      check("rd_valid", bus.rd_valid, m_reading > 0);
      if (m_reading > 0) begin
        check("rd_bit", bus.rd_bit, (m_rd_ch < N_CH) ? m_tab[m_rd_ch][m_reading-1] : 1'b0);
      end
`endif
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_load(input int ch, input logic [DEPTH-1:0] value, input int n_bits,
                          input bit gaps);
    bus.cfg_start = 1'b1;
    bus.cfg_ch    = CH_W'(ch);
    tick();
    bus.cfg_start = 1'b0;
    for (int i = DEPTH - 1; i >= DEPTH - n_bits; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.cfg_valid = 1'b0;
          bus.cfg_bit   = 1'($urandom);
          tick();
        end
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = value[i];
      tick();
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic eval_random(input int cycles);
    repeat (cycles) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = (N_CH*N_IN)'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic sweep();
    for (int v = 0; v < DEPTH; v++) begin
      for (int k = 0; k < N_CH; k++) begin
        bus.in_data[k*N_IN +: N_IN] = N_IN'(v ^ (k * 3));
      end
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin : stimulus
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_start = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
`ifdef PROG_LUT_READBACK_EN
    bus.rd_start  = 1'b0;
    bus.rd_ch     = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Default tables: ch0 index 2 -> 1, ch1 index 3 -> 0.
    bus.in_valid = 1'b1;
    bus.in_data  = {3'b011, 3'b010};
    tick();
    bus.in_valid = 1'b0;
    tick();
    sweep();

    // XOR into ch1 with evaluation running through the load and commit.
    fork
      cfg_load(1, 8'h96, DEPTH, 1'b1);
      eval_random(40);
    join
    tick();
    sweep();

    // cfg_start landing on the commit edge is ignored.
    cfg_load(0, 8'h3C, DEPTH, 1'b0);
    bus.cfg_start = 1'b1;
    bus.cfg_ch    = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    tick();

    // cfg_valid while idle is ignored.
    repeat (4) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'($urandom);
      tick();
    end
    bus.cfg_valid = 1'b0;
    sweep();

    // Abort ch0 after four bits, then load zeros into ch1.
    fork
      begin
        cfg_load(0, 8'hFF, 4, 1'b1);
        cfg_load(1, 8'h00, DEPTH, 1'b1);
        tick();
      end
      eval_random(40);
    join
    sweep();

`ifdef PROG_LUT_READBACK_EN
    cfg_load(1, 8'h96, DEPTH, 1'b0);
    tick();
    bus.rd_start = 1'b1;
    bus.rd_ch    = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    repeat (DEPTH + 2) tick();
    // rd_start during LOAD is ignored.
    cfg_load(0, 8'h5A, 3, 1'b0);
    bus.rd_start = 1'b1;
    bus.rd_ch    = 1'b0;
    tick();
    bus.rd_start = 1'b0;
    cfg_load(0, 8'h5A, DEPTH, 1'b0);
    repeat (2) tick();
`endif

    // Reset in the middle of a load, with evaluation active.
    bus.in_valid = 1'b1;
    bus.in_data  = (N_CH*N_IN)'($urandom);
    cfg_load(0, 8'hAA, 3, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    sweep();

    // Random configuration traffic mixed with random evaluation.
    fork
      begin
        repeat (16) begin
          cfg_load(int'($urandom_range(0, N_CH - 1)), DEPTH'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEPTH - 1)) : DEPTH,
                   1'b1);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      eval_random(400);
    join
    repeat (3) tick();
    sweep();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
